// File: rtl/traffic_light_ctrl.sv
// Two-way intersection controller: six-phase light sequence with
// pedestrian early-termination, hold freeze, 7-seg countdown and 8x8 glyph scan.
module traffic_light_ctrl #(
    parameter int TICK_DIV    = 50000000,
    parameter int SCAN_DIV    = 10000,
    parameter int GREEN_T     = 15,
    parameter int YELLOW_T    = 5,
    parameter int ALLRED_T    = 2,
    parameter int MIN_GREEN_T = 5,
    parameter int CW          = 4
) (
    input  logic          clk1,
    input  logic          rst1,
    input  logic          ped_req,
    input  logic          hold,
    output logic [2:0]    ns_light,
    output logic [2:0]    ew_light,
    output logic [2:0]    phase,
    output logic [CW-1:0] remain,
    output logic [6:0]    out,
    output logic [7:0]    dot_row,
    output logic [7:0]    dot_col
);

    typedef enum logic [2:0] {
        NS_G = 3'd0,
        NS_Y = 3'd1,
        AR1  = 3'd2,
        EW_G = 3'd3,
        EW_Y = 3'd4,
        AR2  = 3'd5
    } phase_e;

    localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

    localparam logic [CW-1:0] G_D  = CW'(GREEN_T);
    localparam logic [CW-1:0] Y_D  = CW'(YELLOW_T);
    localparam logic [CW-1:0] A_D  = CW'(ALLRED_T);
    localparam logic [CW-1:0] MG_D = CW'(MIN_GREEN_T);

    localparam logic [63:0] GLY_G = 64'h0C0C_197E_9818_2848;
    localparam logic [63:0] GLY_Y = 64'h0024_3CBD_FF3C_3C00;
    localparam logic [63:0] GLY_A = 64'h1818_3C3C_5A18_1824;

    logic [TW-1:0] r_tdiv;
    logic [SW-1:0] r_sdiv;
    logic          w_tick;
    logic          w_scan;

    phase_e        r_phase;
    logic [CW-1:0] r_remain;
    logic          r_ped;
    logic [2:0]    r_ns;
    logic [2:0]    r_ew;

    phase_e        w_nph;
    logic [CW-1:0] w_nrem;
    logic [CW-1:0] w_dec;
    logic          w_adv;
    logic          w_enter_ar;

    logic [2:0]    r_row;
    logic [7:0]    r_dot_row;
    logic [7:0]    r_dot_col;
    logic [3:0]    w_nib;

    function automatic phase_e f_next(input phase_e ph);
        case (ph)
            NS_G:    return NS_Y;
            NS_Y:    return AR1;
            AR1:     return EW_G;
            EW_G:    return EW_Y;
            EW_Y:    return AR2;
            default: return NS_G;
        endcase
    endfunction

    function automatic logic [CW-1:0] f_dur(input phase_e ph);
        case (ph)
            NS_G, EW_G: return G_D;
            NS_Y, EW_Y: return Y_D;
            default:    return A_D;
        endcase
    endfunction

    function automatic logic [2:0] f_ns(input phase_e ph);
        case (ph)
            NS_G:    return 3'b001;
            NS_Y:    return 3'b010;
            default: return 3'b100;
        endcase
    endfunction

    function automatic logic [2:0] f_ew(input phase_e ph);
        case (ph)
            EW_G:    return 3'b001;
            EW_Y:    return 3'b010;
            default: return 3'b100;
        endcase
    endfunction

    function automatic logic [7:0] f_glyph(input phase_e ph, input logic [2:0] row);
        logic [63:0] g;
        case (ph)
            NS_G, EW_G: g = GLY_G;
            NS_Y, EW_Y: g = GLY_Y;
            default:    g = GLY_A;
        endcase
        return g[{3'd7 - row, 3'b000} +: 8];
    endfunction

    function automatic logic [6:0] f_seg(input logic [3:0] d);
        case (d)
            4'h0:    return 7'b1000000;
            4'h1:    return 7'b1111001;
            4'h2:    return 7'b0100100;
            4'h3:    return 7'b0110000;
            4'h4:    return 7'b0011001;
            4'h5:    return 7'b0010010;
            4'h6:    return 7'b0000010;
            4'h7:    return 7'b1111000;
            4'h8:    return 7'b0000000;
            4'h9:    return 7'b0010000;
            4'hA:    return 7'b0001000;
            4'hB:    return 7'b0000011;
            4'hC:    return 7'b1000110;
            4'hD:    return 7'b0100001;
            4'hE:    return 7'b0000110;
            default: return 7'b0001110;
        endcase
    endfunction

    assign w_tick = (r_tdiv == TW'(TICK_DIV - 1));
    assign w_scan = (r_sdiv == SW'(SCAN_DIV - 1));

    always_ff @(posedge clk1 or negedge rst1) begin
        if (!rst1) begin
            r_tdiv <= '0;
            r_sdiv <= '0;
        end else begin
            r_tdiv <= w_tick ? '0 : r_tdiv + 1'b1;
            r_sdiv <= w_scan ? '0 : r_sdiv + 1'b1;
        end
    end

    assign w_adv = w_tick && !hold;
    assign w_dec = r_remain - CW'(1);

    always_comb begin
        w_nph  = r_phase;
        w_nrem = r_remain;
        case (r_phase)
            NS_G, NS_Y, AR1, EW_G, EW_Y, AR2: begin
                if (w_adv) begin
                    if (r_remain == CW'(1)) begin
                        w_nph  = f_next(r_phase);
                        w_nrem = f_dur(f_next(r_phase));
                    end else if (r_ped && (r_phase == NS_G || r_phase == EW_G)) begin
                        w_nrem = (w_dec < MG_D) ? w_dec : MG_D;
                    end else begin
                        w_nrem = w_dec;
                    end
                end
            end
            // Corrupted state: recover through an all-red interval
            default: begin
                w_nph  = AR2;
                w_nrem = A_D;
            end
        endcase
    end

    assign w_enter_ar = (w_nph != r_phase) && (w_nph == AR1 || w_nph == AR2);

    always_ff @(posedge clk1 or negedge rst1) begin
        if (!rst1) begin
            r_phase  <= NS_G;
            r_remain <= G_D;
            r_ped    <= 1'b0;
            r_ns     <= 3'b001;
            r_ew     <= 3'b100;
        end else begin
            r_phase  <= w_nph;
            r_remain <= w_nrem;
            r_ns     <= f_ns(w_nph);
            r_ew     <= f_ew(w_nph);
            if (ped_req)
                r_ped <= 1'b1;
            else if (w_enter_ar)
                r_ped <= 1'b0;
        end
    end

    always_ff @(posedge clk1 or negedge rst1) begin
        if (!rst1) begin
            r_row     <= '0;
            r_dot_row <= 8'hFF;
            r_dot_col <= 8'h00;
        end else if (w_scan) begin
            r_row     <= r_row + 3'd1;
            r_dot_row <= ~(8'h80 >> r_row);
            r_dot_col <= f_glyph(r_phase, r_row);
        end
    end

    assign w_nib    = 4'(r_remain);
    assign out      = f_seg(w_nib);
    assign phase    = r_phase;
    assign remain   = r_remain;
    assign ns_light = r_ns;
    assign ew_light = r_ew;
    assign dot_row  = r_dot_row;
    assign dot_col  = r_dot_col;

endmodule
